change_dispense_ctrl: RTL

CHANGE_DISPENSE_CTRL -- requirements
Module: change_dispense_ctrl

---
 rtl/change_pkg.sv | 41 ++++
 rtl/change_denom_sel.sv | 26 ++
 rtl/change_dispense_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/change_pkg.sv
// Shared types and constants for the change dispenser controller.
package change_pkg;

    // Controller states
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CHECK    = 3'd1,
        S_SELECT   = 3'd2,
        S_ISSUE    = 3'd3,
        S_WAIT_ACK = 3'd4,
        S_DONE     = 3'd5,
        S_ERR      = 3'd6
    } state_t;

    // err_code encodings
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_MULT    = 2'd1;
    localparam logic [1:0] ERR_INV     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // Denomination values
    localparam logic [18:0] DENOM_5000 = 19'd5000;
    localparam logic [18:0] DENOM_2000 = 19'd2000;
    localparam logic [18:0] DENOM_1000 = 19'd1000;

    localparam int ACK_TIMEOUT_DEFAULT = 255;

    // One-hot select (bit2=5000, bit1=2000, bit0=1000) to note value
    function automatic logic [18:0] denom_value(input logic [2:0] sel);
        logic [18:0] v;
        v = '0;
        case (sel)
            3'b100:  v = DENOM_5000;
            3'b010:  v = DENOM_2000;
            3'b001:  v = DENOM_1000;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/change_denom_sel.sv
// Greedy denomination chooser: largest note that fits and is in stock.
module change_denom_sel
    import change_pkg::*;
(
    input  logic [18:0] remaining,
    input  logic [6:0]  cnt_5000,
    input  logic [7:0]  cnt_2000,
    input  logic [8:0]  cnt_1000,
    output logic [2:0]  sel,
    output logic        none
);

    // Priority 5000 > 2000 > 1000; none flags that nothing is eligible
    always_comb begin
        sel = 3'b000;
        if (remaining >= DENOM_5000 && cnt_5000 != '0) begin
            sel = 3'b100;
        end else if (remaining >= DENOM_2000 && cnt_2000 != '0) begin
            sel = 3'b010;
        end else if (remaining >= DENOM_1000 && cnt_1000 != '0) begin
            sel = 3'b001;
        end
        none = (sel == 3'b000);
    end

endmodule

// File: rtl/change_dispense_ctrl.sv
// Change dispenser controller: validates a payout amount, then issues
// notes greedily one at a time, waiting for a dispenser ack after each.
// Handshake: a disp_x pulse requests one note; the dispenser answers with
// a one-cycle disp_ack. Ack is registered once, so the next request
// follows two edges after the ack edge. Acks outside WAIT_ACK are dropped.
module change_dispense_ctrl
    import change_pkg::*;
#(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [18:0] amount,
    input  logic [6:0]  inv_5000,
    input  logic [7:0]  inv_2000,
    input  logic [8:0]  inv_1000,
    input  logic        disp_ack,
    output logic        disp_5000,
    output logic        disp_2000,
    output logic        disp_1000,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code,
    output logic [18:0] remaining,
    output logic [2:0]  fsm_state
);

    localparam logic [7:0] TIMER_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state;
    logic [18:0] rem;
    logic [6:0]  cnt_5000;
    logic [7:0]  cnt_2000;
    logic [8:0]  cnt_1000;
    logic [2:0]  sel_q;
    logic [7:0]  timer;
    logic        ack_q;
    logic [1:0]  err_q;
    logic [2:0]  sel;
    logic        none;
    logic [18:0] sel_value;

    change_denom_sel u_sel (
        .remaining (rem),
        .cnt_5000  (cnt_5000),
        .cnt_2000  (cnt_2000),
        .cnt_1000  (cnt_1000),
        .sel       (sel),
        .none      (none)
    );

    assign sel_value = denom_value(sel_q);

    // Payout sequencing, local inventory bookkeeping and error capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            rem      <= '0;
            cnt_5000 <= '0;
            cnt_2000 <= '0;
            cnt_1000 <= '0;
            sel_q    <= '0;
            timer    <= '0;
            ack_q    <= 1'b0;
            err_q    <= ERR_NONE;
        end else begin
            ack_q <= disp_ack && (state == S_WAIT_ACK);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rem      <= amount;
                        cnt_5000 <= inv_5000;
                        cnt_2000 <= inv_2000;
                        cnt_1000 <= inv_1000;
                        err_q    <= ERR_NONE;
                        state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if ((rem % DENOM_1000) != '0) begin
                        err_q <= ERR_MULT;
                        state <= S_ERR;
                    end else begin
                        state <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (rem == '0) begin
                        state <= S_DONE;
                    end else if (none) begin
                        err_q <= ERR_INV;
                        state <= S_ERR;
                    end else begin
                        sel_q <= sel;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer <= '0;
                    state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (ack_q) begin
                        if (rem >= sel_value) begin
                            rem <= rem - sel_value;
                        end
                        if (sel_q[2]) cnt_5000 <= cnt_5000 - 7'd1;
                        if (sel_q[1]) cnt_2000 <= cnt_2000 - 8'd1;
                        if (sel_q[0]) cnt_1000 <= cnt_1000 - 9'd1;
                        state <= S_SELECT;
                    end else if (timer == TIMER_LAST) begin
                        err_q <= ERR_TIMEOUT;
                        state <= S_ERR;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the registered state
    always_comb begin
        disp_5000 = (state == S_ISSUE) && sel_q[2];
        disp_2000 = (state == S_ISSUE) && sel_q[1];
        disp_1000 = (state == S_ISSUE) && sel_q[0];
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        err_code  = err_q;
        remaining = rem;
        fsm_state = state;
    end

endmodule
